// File: rtl/uart_parity_tx.sv
// uart_parity_tx: 4-bit UART transmitter with a parity bit and a one-entry input buffer.
// Frame: start 0, d0..d3 LSB first, parity, stop 1. A two-bit-period wake-up follows reset.
module uart_parity_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_WAKE,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic       wake_q, wake_d;
    logic [3:0] buf_q, buf_d;
    logic       full_q, full_d;
    logic [3:0] sh_q, sh_d;
    logic       tx_q, tx_d;
    logic       bit_end;
    logic       accept;
    logic       load;

    assign bit_end = (cnt_q == LAST);
    assign accept  = in_valid && !full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? 8'd0 : cnt_q + 8'd1;
        idx_d   = idx_q;
        wake_d  = wake_q;
        buf_d   = buf_q;
        full_d  = full_q;
        sh_d    = sh_q;
        load    = 1'b0;
        tx_d    = 1'b1;

        if (accept) begin
            buf_d  = in_data;
            full_d = 1'b1;
        end

        unique case (state_q)
            S_WAKE: begin
                if (bit_end) begin
                    wake_d = ~wake_q;
                    if (wake_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                cnt_d = 8'd0;
                load  = full_q;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = 2'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_PARITY;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_WAKE;
            end
        endcase

        // Loading only happens with a full buffer, so it never races a new accept.
        if (load) begin
            state_d = S_START;
            sh_d    = buf_q;
            full_d  = 1'b0;
        end

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[idx_d];
            S_PARITY: tx_d = ^sh_q ^ PARITY_ODD;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_WAKE;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            wake_q  <= 1'b0;
            buf_q   <= 4'd0;
            full_q  <= 1'b0;
            sh_q    <= 4'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wake_q  <= wake_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign in_ready   = !full_q;
    assign tx         = tx_q;
    assign busy       = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
    assign frame_done = (state_q == S_STOP) && bit_end;

endmodule
